lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the 2^16 x 32 word RAM.
- Accepts byte-addressed byte, halfword and word requests from the CPU execute stage.
- Drives the RAM's word address, data and enables, and returns a sign- or zero-extended load result or a store acknowledgement.
- Sub-word stores are done by read-modify-write, because the RAM has no byte enables.

Parameters:
- DATA_W, 32, data word width; matches the RAM word width.
- WADDR_W, 16, RAM word-address width.
- ADDR_W, 18, CPU byte-address width (WADDR_W+2).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request; high only in IDLE.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  00=byte, 01=half, 10=word, 11=reserved (flagged as error).
- req_signed  input  1  loads only: sign-extend when 1.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data; the value sits right-justified.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_data  output  DATA_W  load result; 0 for stores and errors.
- rsp_err  output  1  misaligned access or reserved size; valid with rsp_valid.
- ram_addr  output  WADDR_W  word address, equal to the latched req_addr[ADDR_W-1:2].
- ram_wdata  output  DATA_W  data word for the RAM.
- ram_we  output  1  RAM write enable.
- ram_re  output  1  RAM read enable.
- ram_rdata  input  DATA_W  RAM registered read data; valid the cycle after an edge sampled with ram_re=1.

Behaviour:
- Reset values: req_ready=0 while rst is high and 1 after release; all other outputs 0; state IDLE.
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready; all req_* fields are latched at that edge.
  - req_valid may drop after acceptance.
  - There is no response backpressure: the requester must take the rsp_valid pulse.
- Byte order is little-endian.
  - Byte lane = addr[1:0].
  - Half lane = addr[1]; a half access requires addr[0]=0.
  - A word access requires addr[1:0]=00.
- States: IDLE, RD, CAP, WR, RESP. All RAM outputs are registered or decoded from state only.
  - IDLE: req_ready=1. On accept:
    - misaligned or size=11 -> RESP with err=1, no RAM access;
    - load or sub-word store -> RD;
    - word store -> WR.
  - RD: ram_re=1 for exactly one cycle -> CAP.
  - CAP: sample ram_rdata.
    - Load: extract the lane, extend it, register it into rsp_data -> RESP.
    - Sub-word store: merge req_wdata into the selected lane of the sampled word, keep the other lanes, register the result into ram_wdata -> WR.
  - WR: ram_we=1 for exactly one cycle, ram_re=0 -> RESP.
  - RESP: rsp_valid=1 for one cycle -> IDLE.
- rsp_data/rsp_err hold until the next accept; rsp_err is cleared on each accept.
- ram_we and ram_re are never high together.
- Latency, counted from the accept edge to the rsp_valid cycle:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - error: 1 cycle.
- Throughput: at most one request in flight; back-to-back requests are spaced by the latency plus 1.
- Reset mid-operation:
  - FSM returns to IDLE immediately and ram_we/ram_re go low asynchronously.
  - The in-flight request is dropped with no response.
  - A partially completed read-modify-write leaves the RAM word unchanged, because WR had not yet been reached.
- Address wrap: top byte address 0x3FFFF maps to word 0xFFFF; no wrap beyond the RAM.

Optional Feature:
- Macro LSU_MEM_CTRL_STATS_EN.
- When defined: adds outputs stat_loads, stat_stores and stat_errs, each 16 bits.
  - Counters are saturating and increment in the RESP cycle.
  - rst clears them to 0.
- When undefined: those ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package lsu_mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - state encoding;
  - alignment-check function.
- Sub-module lsu_align (combinational):
  - load lane extract with sign/zero extension;
  - store lane merge.
- The FSM stays in lsu_mem_ctrl.

Test Plan:
- Preload RAM word 0x0010=0x80FF7F01.
  - Byte signed load addr 0x00042 -> rsp_data=0xFFFFFFFF.
  - Byte unsigned load addr 0x00043 -> 0x00000080.
  - rsp_valid arrives 3 cycles after accept in both cases.
- Word store 0xDEADBEEF to addr 0x00100 -> ram_we pulse with ram_addr=0x0040; a later word load returns 0xDEADBEEF; store latency 2 cycles.
- Half store 0x1234 to addr 0x00102 over word 0xAAAAAAAA -> RAM word becomes 0x1234AAAA; exactly one ram_re and one ram_we pulse.
- Half load addr 0x00101 -> rsp_err=1, rsp_data=0, no ram_re/ram_we, latency 1 cycle; repeat with req_size=11 -> same response.
- Assert rst during CAP of a byte store -> outputs 0 immediately, no rsp_valid, RAM word unchanged; the next request completes normally.
- With LSU_MEM_CTRL_STATS_EN: issue 2 loads, 1 store, 1 error -> stat_loads=2, stat_stores=1, stat_errs=1.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the load/store controller.
//   size_e    : request size encoding (byte/half/word/reserved)
//   state_e   : controller FSM state encoding
//   access_err: flags reserved size or a misaligned byte offset
//   sat_inc16 : saturating increment for the optional statistics counters
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // 1 when the access cannot be performed: reserved size, a half on an
  // odd byte, or a word not on a word boundary.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = off[0];
      SZ_WORD: err = |off;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store controller (little-endian).
//   size       : request size (byte/half/word)
//   sign_ext   : sign-extend loads when 1
//   lane       : byte offset within the word (addr[1:0])
//   rdata      : word read from RAM
//   wdata      : right-justified store data
//   load_data  : extracted and extended load result
//   merge_data : rdata with the selected lane replaced by wdata
module lsu_align
  import lsu_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    load_data  = '0;
    merge_data = rdata;
    byte_v     = rdata[{lane, 3'b000} +: 8];
    half_v     = rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        load_data = {{(DATA_W-8){sign_ext & byte_v[7]}}, byte_v};
        merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{(DATA_W-16){sign_ext & half_v[15]}}, half_v};
        merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a 2^WADDR_W x DATA_W word RAM without
// byte enables. Sub-word stores are read-modify-write.
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   req_*             : CPU request (valid/ready handshake, accepted in IDLE)
//   rsp_valid/data/err: one-cycle response; data/err hold until next accept
//   ram_*             : RAM word address, write data, enables, registered rdata
// Optional: define LSU_MEM_CTRL_STATS_EN to add saturating 16-bit counters
//   stat_loads, stat_stores, stat_errs (bumped in the RESP cycle).
module lsu_mem_ctrl
  import lsu_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WADDR_W = 16,
  parameter int ADDR_W  = WADDR_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic [WADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               ram_we,
  output logic               ram_re,
  input  logic [DATA_W-1:0]  ram_rdata
`ifdef LSU_MEM_CTRL_STATS_EN
  ,
  output logic [15:0]        stat_loads,
  output logic [15:0]        stat_stores,
  output logic [15:0]        stat_errs
`endif
);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  size_e              size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [1:0]         off_q, off_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]  load_data, merge_data;
  logic               acc_err;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size       (size_q),
    .sign_ext   (sgn_q),
    .lane       (off_q),
    .rdata      (ram_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // RAM enables and the response strobe are pure state decodes, so an
  // async reset drops them in the same instant the state clears.
  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign ram_re    = (state_q == ST_RD);
  assign ram_we    = (state_q == ST_WR);
  assign rsp_valid = (state_q == ST_RESP);
  assign ram_addr  = waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  assign acc_err = access_err(req_size, req_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    ram_wdata_d = ram_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d       = req_we;
          size_d     = size_e'(req_size);
          sgn_d      = req_signed;
          off_d      = req_addr[1:0];
          waddr_d    = req_addr[ADDR_W-1:2];
          wdata_d    = req_wdata;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (acc_err) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            // Full-word store needs no read: data goes straight to the RAM.
            ram_wdata_d = req_wdata;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        if (we_q) begin
          ram_wdata_d = merge_data;
          state_d     = ST_WR;
        end else begin
          rsp_data_d = load_data;
          state_d    = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      off_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ram_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef LSU_MEM_CTRL_STATS_EN
  logic [15:0] stat_loads_q, stat_loads_d;
  logic [15:0] stat_stores_q, stat_stores_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  // Errors are classed as errors regardless of direction.
  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == ST_RESP) begin
      if (rsp_err_q)  stat_errs_d   = sat_inc16(stat_errs_q);
      else if (we_q)  stat_stores_d = sat_inc16(stat_stores_q);
      else            stat_loads_d  = sat_inc16(stat_loads_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed test-plan cases followed by
// randomized traffic against a byte-level reference model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we, ram_re;
`ifdef LSU_MEM_CTRL_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_re(ram_re), .ram_rdata(ram_rdata)
`ifdef LSU_MEM_CTRL_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  // RAM with registered read data
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // reference model state
  logic [31:0] ref_mem [0:65535];
  int total = 0, bad = 0;
  int e_ld = 0, e_st = 0, e_er = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_err(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || ((int'(off) % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic sg, input logic [1:0] off);
    logic [63:0] msk;
    logic [31:0] v;
    int nb;
    nb  = nbytes(sz);
    msk = (64'd1 << (8 * nb)) - 64'd1;
    v   = (w >> (8 * off)) & msk[31:0];
    if (sg && nb < 4 && v[8*nb-1]) v = v | ~msk[31:0];
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] off);
    logic [63:0] msk;
    logic [31:0] m;
    msk = (64'd1 << (8 * nbytes(sz))) - 64'd1;
    m   = msk[31:0] << (8 * off);
    return (w & ~m) | ((wd << (8 * off)) & m);
  endfunction

  // Drive one request starting at a negedge in IDLE; observe until response,
  // returning at the negedge after the response pulse.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [17:0] a, input logic [31:0] wd,
                        output logic [31:0] d, output logic e, output int lat,
                        output int nre, output int nwe,
                        output logic [15:0] wa, output logic [31:0] wdat);
    bit got;
    got = 0; lat = 0; nre = 0; nwe = 0; wa = '0; wdat = '0; d = '0; e = 1'b0;
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    // scramble fields after accept: the DUT must use its latched copy
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = 18'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 8 && !got; c++) begin
      chk("re_we_excl", {31'b0, ram_re & ram_we}, 32'd0);
      if (ram_re) nre++;
      if (ram_we) begin nwe++; wa = ram_addr; wdat = ram_wdata; end
      if (rsp_valid) begin got = 1; lat = c; d = rsp_data; e = rsp_err; end
      @(negedge clk);
    end
    chk("rsp_seen", {31'b0, got}, 32'd1);
    chk("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
    chk("rsp_hold", rsp_data, d);
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [17:0] a, input logic [31:0] wd,
                         output logic [31:0] d);
    logic [31:0] w, exp_d, nw, wdat;
    logic [15:0] wa;
    logic        exp_e, e;
    int          exp_lat, exp_re, exp_we, lat, nre, nwe;
    w = ref_mem[a[17:2]];
    exp_e = m_err(sz, a[1:0]);
    exp_d = '0; nw = w;
    if (exp_e) begin
      exp_lat = 1; exp_re = 0; exp_we = 0;
    end else if (!we) begin
      exp_d = m_load(w, sz, sg, a[1:0]); exp_lat = 3; exp_re = 1; exp_we = 0;
    end else begin
      nw = m_merge(w, wd, sz, a[1:0]);
      exp_lat = (sz == 2'd2) ? 2 : 4; exp_re = (sz == 2'd2) ? 0 : 1; exp_we = 1;
    end
    do_req(we, sz, sg, a, wd, d, e, lat, nre, nwe, wa, wdat);
    chk({tag, ".data"}, d, exp_d);
    chk({tag, ".err"}, {31'b0, e}, {31'b0, exp_e});
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".nre"}, nre, exp_re);
    chk({tag, ".nwe"}, nwe, exp_we);
    if (we && !exp_e) begin
      chk({tag, ".waddr"}, {16'b0, wa}, {16'b0, a[17:2]});
      chk({tag, ".wdata"}, wdat, nw);
      ref_mem[a[17:2]] = nw;
    end
    if (exp_e) e_er++;
    else if (we) e_st++;
    else e_ld++;
  endtask

  initial begin
    logic [31:0] d;
    logic [17:0] a;
    logic [15:0] wi;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    ram_rdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'b0, req_ready}, 32'd0);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.ram_en", {30'b0, ram_we, ram_re}, 32'd0);
    chk("rst.ram_addr", {16'b0, ram_addr}, 32'd0);
    chk("rst.ram_wdata", ram_wdata, 32'd0);
    chk("rst.rsp", {rsp_data[30:0], rsp_err} | {31'b0, rsp_data[31]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_rel", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    // byte loads from a preloaded word
    run_chk("pre10", 1'b1, 2'b10, 1'b0, 18'h00040, 32'h80FF7F01, d);
    run_chk("lb_s", 1'b0, 2'b00, 1'b1, 18'h00042, 32'h0, d);
    chk("lb_s.const", d, 32'hFFFFFFFF);
    run_chk("lbu", 1'b0, 2'b00, 1'b0, 18'h00043, 32'h0, d);
    chk("lbu.const", d, 32'h00000080);

    // word store then load back
    run_chk("sw", 1'b1, 2'b10, 1'b0, 18'h00100, 32'hDEADBEEF, d);
    chk("sw.mem", mem[16'h0040], 32'hDEADBEEF);
    run_chk("lw", 1'b0, 2'b10, 1'b0, 18'h00100, 32'h0, d);
    chk("lw.const", d, 32'hDEADBEEF);

    // half store via read-modify-write
    run_chk("sw_a", 1'b1, 2'b10, 1'b0, 18'h00100, 32'hAAAAAAAA, d);
    run_chk("sh", 1'b1, 2'b01, 1'b0, 18'h00102, 32'h00001234, d);
    chk("sh.mem", mem[16'h0040], 32'h1234AAAA);

    // errors
    run_chk("lh_mis", 1'b0, 2'b01, 1'b1, 18'h00101, 32'h0, d);
    run_chk("rsvd", 1'b0, 2'b11, 1'b0, 18'h00101, 32'h0, d);
    run_chk("sw_mis", 1'b1, 2'b10, 1'b0, 18'h00102, 32'h55555555, d);
    chk("sw_mis.mem", mem[16'h0040], 32'h1234AAAA);

    // top of address space
    run_chk("sw_top", 1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'h9A000000, d);
    run_chk("lb_top", 1'b0, 2'b00, 1'b1, 18'h3FFFF, 32'h0, d);
    chk("lb_top.const", d, 32'hFFFFFF9A);
    chk("sw_top.mem", mem[16'hFFFF], 32'h9A000000);

    // reset during CAP of a byte store
    chk("rrst.ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 18'h00041; req_wdata = 32'h00000055;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rrst.rd_re", {31'b0, ram_re}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rrst.ram_en", {30'b0, ram_we, ram_re}, 32'd0);
    chk("rrst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rrst.ready", {31'b0, req_ready}, 32'd0);
    chk("rrst.ram_wdata", ram_wdata, 32'd0);
    chk("rrst.ram_addr", {16'b0, ram_addr}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rrst.quiet", {30'b0, rsp_valid, ram_we}, 32'd0);
    end
    rst = 1'b0;
    e_ld = 0; e_st = 0; e_er = 0;
    #1;
    chk("rrst.mem", mem[16'h0010], ref_mem[16'h0010]);
    @(negedge clk);
    run_chk("after_rst", 1'b0, 2'b00, 1'b1, 18'h00041, 32'h0, d);

    // random traffic over words 0..15 and the top word
    for (int i = 0; i < 16; i++)
      run_chk("seed", 1'b1, 2'b10, 1'b0, {i[15:0], 2'b00}, $urandom, d);
    for (int i = 0; i < 150; i++) begin
      wi = ($urandom_range(0, 16) == 16) ? 16'hFFFF : 16'($urandom_range(0, 15));
      a  = {wi, 2'($urandom)};
      run_chk("rnd", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, d);
    end
    for (int i = 0; i < 16; i++)
      chk("rnd.mem", mem[i], ref_mem[i]);

`ifdef LSU_MEM_CTRL_STATS_EN
    chk("stat_loads", {16'b0, stat_loads}, e_ld);
    chk("stat_stores", {16'b0, stat_stores}, e_st);
    chk("stat_errs", {16'b0, stat_errs}, e_er);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
